// File: rtl/ha4_add_sched.sv
// rtl/ha4_add_sched.sv - two-requester adder scheduler built on one iterative half-adder datapath
module ha4_add_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic [4:0]   rsp_steps,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state_q, state_nx;
  logic [W-1:0] x_q, x_nx;
  logic [W-1:0] y_q, y_nx;
  logic         cout_q, cout_nx;
  logic [4:0]   steps_q, steps_nx;
  logic         id_q, id_nx;
  logic         last_q, last_nx;

  logic [W-1:0] hs, hc;
  logic         gnt_any, gnt_idx, rdy_en, done;

  assign hs = x_q ^ y_q;
  assign hc = x_q & y_q;

  // Round-robin only matters on contention; a lone requester always wins.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_idx = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  // Gated with rst_n so the readys stay low while reset is held.
  assign rdy_en     = rst_n && (state_q == IDLE);
  assign req0_ready = rdy_en && gnt_any && !gnt_idx;
  assign req1_ready = rdy_en && gnt_any && gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      steps_q <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      cout_q  <= cout_nx;
      steps_q <= steps_nx;
      id_q    <= id_nx;
      last_q  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    x_nx     = x_q;
    y_nx     = y_q;
    cout_nx  = cout_q;
    steps_nx = steps_q;
    id_nx    = id_q;
    last_nx  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          x_nx     = gnt_idx ? req1_a : req0_a;
          y_nx     = gnt_idx ? req1_b : req0_b;
          cout_nx  = 1'b0;
          steps_nx = '0;
          id_nx    = gnt_idx;
          last_nx  = gnt_idx;
          state_nx = CALC;
        end
      end
      CALC: begin
        // Carry word shifts left each step, so it empties within W iterations.
        if (y_q != '0) begin
          x_nx     = hs;
          y_nx     = {hc[W-2:0], 1'b0};
          cout_nx  = cout_q | hc[W-1];
          steps_nx = steps_q + 5'd1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done      = (state_q == DONE);
  assign rsp_valid = done;
  assign rsp_sum   = done ? x_q : '0;
  assign rsp_cout  = done && cout_q;
  assign rsp_steps = done ? steps_q : 5'd0;
  assign rsp_id    = done && id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ha4_add_sched.sv
// tb/tb_ha4_add_sched.sv - directed and exhaustive checks of ha4_add_sched at W=4
module tb_ha4_add_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;
  logic [4:0]   rsp_steps;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sel; int a; int b; int sum; int cout; int steps;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  ha4_add_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_steps(rsp_steps), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, rsp_valid, 0);
    chk({nm, "_sum"}, rsp_sum, 0);
    chk({nm, "_cout"}, rsp_cout, 0);
    chk({nm, "_steps"}, rsp_steps, 0);
    chk({nm, "_id"}, rsp_id, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ready0"}, req0_ready, 0);
    chk({nm, "_ready1"}, req1_ready, 0);
  endtask

  task automatic start_req(input int sel, input int a, input int b);
    @(negedge clk);
    if (sel == 0) begin
      req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b);
    end else begin
      req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b);
    end
    #1;
    chk("accept_ready", (sel == 0) ? int'(req0_ready) : int'(req1_ready), 1);
    chk("other_ready", (sel == 0) ? int'(req1_ready) : int'(req0_ready), 0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req0_b = ~req0_b; req1_a = ~req1_a; req1_b = ~req1_b;
  endtask

  // n = rising edges after the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!rsp_valid && n < 30);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
    chk("idle_after_xfer", busy, 0);
    chk("valid_after_xfer", rsp_valid, 0);
  endtask

  initial begin
    int n;
    vecs = '{
      '{0, 3, 0, 3, 0, 0}, '{1, 1, 15, 0, 1, 4}, '{0, 5, 6, 11, 0, 2}, '{1, 9, 9, 2, 1, 2},
      '{0, 0, 0, 0, 0, 0}, '{1, 15, 15, 14, 1, 2}, '{0, 15, 1, 0, 1, 4}, '{1, 8, 8, 0, 1, 1},
      '{0, 6, 3, 9, 0, 3}, '{1, 10, 5, 15, 0, 1}, '{0, 2, 2, 4, 0, 2}, '{1, 7, 9, 0, 1, 4}
    };
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = 4'd5; req0_b = 4'd6; req1_a = 4'd9; req1_b = 4'd9;
    #2 rst_n = 1'b0;
    #10 chk_zero("reset");

    // Contention straight out of reset: req0 first, then strict alternation.
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("first_ready0", req0_ready, 1);
    chk("first_ready1", req1_ready, 0);
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      chk("rr_id", rsp_id, i % 2);
      chk("rr_sum", rsp_sum, (i % 2) ? 2 : 11);
      chk("rr_cout", rsp_cout, (i % 2) ? 1 : 0);
      chk("rr_steps", rsp_steps, 2);
      @(posedge clk);
    end
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_req(vecs[i].sel, vecs[i].a, vecs[i].b);
      wait_rsp(n);
      chk("vec_latency", n, vecs[i].steps + 1);
      chk("vec_id", rsp_id, vecs[i].sel);
      chk("vec_sum", rsp_sum, vecs[i].sum);
      chk("vec_cout", rsp_cout, vecs[i].cout);
      chk("vec_steps", rsp_steps, vecs[i].steps);
      finish_rsp();
    end

    // Back-pressure: response held for 5 cycles while new requests are ignored.
    rsp_ready = 1'b0;
    start_req(0, 6, 3);
    wait_rsp(n);
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, 9);
      chk("hold_cout", rsp_cout, 0);
      chk("hold_steps", rsp_steps, 3);
      chk("hold_id", rsp_id, 0);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
    end
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", busy, 0);
    chk("release_valid", rsp_valid, 0);

    // Reset mid-calculation, asserted between clock edges.
    start_req(1, 7, 9);
    @(posedge clk);
    @(negedge clk);
    chk("calc_busy", busy, 1);
    req0_valid = 1'b1; req1_valid = 1'b1; rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    start_req(0, 2, 2);
    wait_rsp(n);
    chk("post_reset_sum", rsp_sum, 4);
    chk("post_reset_id", rsp_id, 0);
    chk("post_reset_cout", rsp_cout, 0);
    finish_rsp();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_req(0, a, b);
        wait_rsp(n);
        chk("exh_sum", {27'd0, rsp_cout, rsp_sum}, a + b);
        chk("exh_steps_le_w", int'(rsp_steps <= 5'd4), 1);
        chk("exh_latency", n, int'(rsp_steps) + 1);
        @(posedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
